// File: rtl/mipi_tx_line_scheduler.sv
// Per-line read scheduler for the MIPI TX pixel FIFO: waits for enough data, issues
// exactly H_WORDS reads per line, counts lines per frame, flushes at frame start.
module mipi_tx_line_scheduler #(
    parameter logic [11:0]  V_ACTIVE    = 12'd2160,
    parameter logic [11:0]  H_WORDS     = 12'd810,
    parameter int           LEVEL_W     = 12,
    parameter logic [LEVEL_W-1:0] START_LEVEL = LEVEL_W'(64),
    parameter logic [3:0]   FLUSH_LEN   = 4'd4
) (
    input  logic               CLK_tx,
    input  logic               RST,
    input  logic               Vsync,
    input  logic               Hsync,
    input  logic               frame_start,
    input  logic               tx_fifo_req,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               fifo_empty,
    output logic               fifo_readen,
    output logic               fifo_rst,
    output logic [11:0]        line_cnt,
    output logic [11:0]        word_cnt,
    output logic               frame_done,
    output logic               underrun_err,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_WAIT_LVL = 3'd2;
    localparam logic [2:0] S_READ     = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]  state_reg, state_next;
    logic [3:0]  flush_cnt_reg, flush_cnt_next;
    logic [11:0] line_cnt_reg, line_cnt_next;
    logic [11:0] word_cnt_reg, word_cnt_next;
    logic        frame_done_reg, frame_done_next;
    logic        underrun_err_reg, underrun_err_next;
    logic [11:0] line_inc;
    logic        last_line;

    // Vsync and reset suppress the strobe immediately so an aborted line never pops a word.
    assign fifo_readen  = (state_reg == S_READ) && tx_fifo_req && !fifo_empty && !Vsync && !RST;
    assign fifo_rst     = (flush_cnt_reg != 4'd0);
    assign line_cnt     = line_cnt_reg;
    assign word_cnt     = word_cnt_reg;
    assign frame_done   = frame_done_reg;
    assign underrun_err = underrun_err_reg;
    assign state_dbg    = state_reg;

    assign line_inc  = line_cnt_reg + 12'd1;
    assign last_line = (line_inc == V_ACTIVE);

    always_comb begin
        state_next        = state_reg;
        flush_cnt_next    = fifo_rst ? flush_cnt_reg - 4'd1 : 4'd0;
        line_cnt_next     = line_cnt_reg;
        word_cnt_next     = word_cnt_reg;
        frame_done_next   = 1'b0;
        underrun_err_next = underrun_err_reg;
        if (Vsync) begin
            line_cnt_next  = 12'd0;
            word_cnt_next  = 12'd0;
            flush_cnt_next = FLUSH_LEN;
            state_next     = S_ARMED;
        end else begin
            case (state_reg)
                S_ARMED: begin
                    if (Hsync && frame_start && !fifo_rst) begin
                        word_cnt_next = 12'd0;
                        state_next    = S_WAIT_LVL;
                    end
                end
                S_WAIT_LVL: begin
                    if (Hsync) begin
                        // Next line began before this one could start: count it as missed.
                        underrun_err_next = 1'b1;
                        line_cnt_next     = line_inc;
                        state_next        = last_line ? S_DONE : S_WAIT_LVL;
                        frame_done_next   = last_line;
                    end else if (fifo_level >= START_LEVEL && tx_fifo_req) begin
                        state_next = S_READ;
                    end
                end
                S_READ: begin
                    if (Hsync) begin
                        underrun_err_next = 1'b1;
                        line_cnt_next     = line_inc;
                        word_cnt_next     = 12'd0;
                        state_next        = last_line ? S_DONE : S_WAIT_LVL;
                        frame_done_next   = last_line;
                    end else if (fifo_readen) begin
                        word_cnt_next = word_cnt_reg + 12'd1;
                        if (word_cnt_reg == H_WORDS - 12'd1) begin
                            line_cnt_next   = line_inc;
                            state_next      = last_line ? S_DONE : S_HOLD;
                            frame_done_next = last_line;
                        end
                    end else if (tx_fifo_req && fifo_empty) begin
                        underrun_err_next = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!frame_start) begin
                        state_next = S_ARMED;
                    end else if (Hsync) begin
                        word_cnt_next = 12'd0;
                        state_next    = S_WAIT_LVL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK_tx) begin
        if (RST) begin
            state_reg        <= S_IDLE;
            flush_cnt_reg    <= 4'd0;
            line_cnt_reg     <= 12'd0;
            word_cnt_reg     <= 12'd0;
            frame_done_reg   <= 1'b0;
            underrun_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            flush_cnt_reg    <= flush_cnt_next;
            line_cnt_reg     <= line_cnt_next;
            word_cnt_reg     <= word_cnt_next;
            frame_done_reg   <= frame_done_next;
            underrun_err_reg <= underrun_err_next;
        end
    end

endmodule
